hps_cmd_regs: RTL

Avalon-MM responder that terminates HPS byte writes to the FPGA and turns them into whole drawing commands for the renderer. Bytes written to addresses 0–5 are staged. A write to address 6 commits all seven bytes as one 56-bit command into a small FIFO. The renderer drains the FIFO through a valid/ready port. Sits inside `fpga_top_level`, between the HPS bridge pins and the sprite/raster engine.

---
 rtl/hps_cmd_regs.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/hps_cmd_regs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hps_cmd_regs : HPS byte-register front end that packs 7 bytes into one     |
// |                56-bit draw command and queues it for the renderer.         |
// | Optional feature macro: HPS_CMD_VBLANK_GATE_EN (drain only during vblank). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hps_cmd_regs #(
    parameter int DEPTH = 8
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic        hps_chipselect,
    input  logic        hps_write,
    input  logic        hps_read,
    input  logic [2:0]  hps_address,
    input  logic [7:0]  hps_writedata,
    output logic [7:0]  hps_readdata,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [55:0] cmd_data,
    input  logic        vblank,
    output logic        overflow
);

    localparam int         C_AW    = $clog2(DEPTH);
    localparam logic [3:0] C_DEPTH = 4'(DEPTH);

    logic [7:0]      stage_q [6];
    logic [7:0]      stage_d [6];
    logic [55:0]     mem_q [DEPTH];
    logic [55:0]     mem_d [DEPTH];
    logic [C_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [C_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]      count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      readdata_q, readdata_d;

    logic w_wr, w_rd, w_commit, w_ctrl, w_flush, w_clear;
    logic w_empty, w_full, w_gate, w_valid, w_pop, w_room, w_push, w_drop;
    logic [55:0] w_cmd;

`ifdef HPS_CMD_VBLANK_GATE_EN
    assign w_gate = vblank;
`else
    logic w_unused;
    assign w_gate   = 1'b1;
    assign w_unused = vblank;
`endif

    assign w_wr     = hps_chipselect & hps_write;
    assign w_rd     = hps_chipselect & hps_read;
    assign w_commit = w_wr & (hps_address == 3'd6);
    assign w_ctrl   = w_wr & (hps_address == 3'd7);
    assign w_flush  = w_ctrl & hps_writedata[1];
    assign w_clear  = w_ctrl & hps_writedata[0];
    assign w_empty  = (count_q == 4'd0);
    assign w_full   = (count_q == C_DEPTH);
    assign w_valid  = !w_empty & w_gate;
    assign w_pop    = w_valid & cmd_ready;
    // A pop in the same cycle frees the slot the commit needs.
    assign w_room   = (count_q < C_DEPTH) | w_pop;
    assign w_push   = w_commit & w_room & !w_flush;
    assign w_drop   = w_commit & !w_room & !w_flush;
    assign w_cmd    = {hps_writedata, stage_q[5], stage_q[4], stage_q[3],
                       stage_q[2], stage_q[1], stage_q[0]};

    always_comb begin
        stage_d    = stage_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        readdata_d = readdata_q;

        for (int i = 0; i < 6; i++) begin
            if (w_wr && (hps_address == 3'(i))) begin
                stage_d[i] = hps_writedata;
            end
        end

        if (w_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = 4'd0;
        end else begin
            if (w_push) begin
                mem_d[wr_ptr_q] = w_cmd;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (w_push && !w_pop) begin
                count_d = count_q + 4'd1;
            end else if (!w_push && w_pop) begin
                count_d = count_q - 4'd1;
            end
        end

        if (w_drop) begin
            overflow_d = 1'b1;
        end else if (w_clear) begin
            overflow_d = 1'b0;
        end

        if (w_rd) begin
            readdata_d = 8'h00;
            for (int i = 0; i < 6; i++) begin
                if (hps_address == 3'(i)) begin
                    readdata_d = stage_q[i];
                end
            end
            if (hps_address == 3'd7) begin
                readdata_d = {overflow_q, w_full, w_empty, 1'b0, count_q};
            end
        end
    end

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 6; i++) begin
                stage_q[i] <= 8'h00;
            end
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= 4'd0;
            overflow_q <= 1'b0;
            readdata_q <= 8'h00;
        end else begin
            stage_q    <= stage_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            readdata_q <= readdata_d;
        end
    end

    assign hps_readdata = readdata_q;
    assign cmd_valid    = w_valid;
    assign cmd_data     = w_valid ? mem_q[rd_ptr_q] : 56'd0;
    assign overflow     = overflow_q;

endmodule
`default_nettype wire
